// File: rtl/alu_operand_entry.sv
// Decimal operand/selector entry front end for the ALU: collects two 1-2 digit
// decimal operands and an op code, range-checks them, then issues with valid/ready.
module alu_operand_entry #(
    parameter int OPW  = 4,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic [3:0]      digit_in,
    input  logic            digit_valid,
    input  logic            enter,
    input  logic [SELW-1:0] op_in,
    output logic [OPW-1:0]  alu_in1,
    output logic [OPW-1:0]  alu_in2,
    output logic [SELW-1:0] alu_selector,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [6:0]      entry_value,
    output logic [1:0]      digit_count,
    output logic [1:0]      state,
    output logic            err
);

    localparam logic [31:0] MAXV = 32'((1 << OPW) - 1);

    typedef enum logic [1:0] {S_A = 2'b00, S_B = 2'b01, S_OP = 2'b10, S_ISSUE = 2'b11} state_t;

    typedef struct packed {
        logic [OPW-1:0]  a;
        logic [OPW-1:0]  b;
        logic [SELW-1:0] sel;
    } issue_t;

    state_t     state_q, state_d;
    issue_t     issue_q, issue_d;
    logic [6:0] acc_q, acc_d;
    logic [1:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       vld_q, vld_d;

    logic digit_ok, field_ok;

    assign digit_ok = (digit_in <= 4'd9) && (cnt_q != 2'd2);
    // Range check runs on the full accumulator, before truncation to OPW bits.
    assign field_ok = (cnt_q != 2'd0) && (32'(acc_q) <= MAXV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_A;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_A;
        end else begin
            case (state_q)
                S_A:     if (enter && field_ok) state_d = S_B;
                S_B:     if (enter && field_ok) state_d = S_OP;
                S_OP:    if (enter) state_d = S_ISSUE;
                S_ISSUE: if (vld_q && issue_ready) state_d = S_A;
                default: state_d = S_A;
            endcase
        end
    end

    // Enter outranks a same-cycle digit: it commits the pre-digit accumulator.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        vld_d   = vld_q;
        issue_d = issue_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            err_d = 1'b0;
            vld_d = 1'b0;
        end else begin
            case (state_q)
                S_A, S_B: begin
                    if (enter) begin
                        if (field_ok) begin
                            if (state_q == S_A) issue_d.a = acc_q[OPW-1:0];
                            else                issue_d.b = acc_q[OPW-1:0];
                            acc_d = '0;
                            cnt_d = '0;
                            err_d = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (digit_valid) begin
                        if (digit_ok) begin
                            acc_d = acc_q * 7'd10 + {3'b000, digit_in};
                            cnt_d = cnt_q + 2'd1;
                            err_d = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_OP: begin
                    if (enter) begin
                        issue_d.sel = op_in;
                        vld_d       = 1'b1;
                    end
                end
                S_ISSUE: if (vld_q && issue_ready) vld_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            issue_q <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            issue_q <= issue_d;
        end
    end

    assign alu_in1      = issue_q.a;
    assign alu_in2      = issue_q.b;
    assign alu_selector = issue_q.sel;
    assign issue_valid  = vld_q;
    assign entry_value  = acc_q;
    assign digit_count  = cnt_q;
    assign state        = state_q;
    assign err          = err_q;

endmodule

// File: doc/alu_operand_entry.md
Name: alu_operand_entry

Overview:
- Sequential front end that produces the ALU operand and selector inputs, taking the place of a hand-driven stimulus.
- The user enters two decimal operands (up to two digits each) and an operation code. The block converts each operand from decimal to binary and range-checks it.
- The completed operation is then issued to the ALU/display path with a valid/ready handshake.
- This is the input counterpart of the ALU's binary-to-decimal display path.

Parameters:
- OPW, 4, operand width in bits; accepted operand range is 0..2^OPW-1 (0..15 at default)
- SELW, 2, selector width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort; returns to operand-A entry
- digit_in  in  4  decimal digit, qualified by digit_valid
- digit_valid  in  1  one-cycle digit strobe
- enter  in  1  one-cycle strobe that commits the current field
- op_in  in  SELW  operation code, sampled on enter in S_OP
- alu_in1  out  OPW  committed operand A (registered)
- alu_in2  out  OPW  committed operand B (registered)
- alu_selector  out  SELW  committed selector (registered)
- issue_valid  out  1  operation ready for the ALU
- issue_ready  in  1  ALU side accepts the operation
- entry_value  out  7  accumulator for live display (0..99)
- digit_count  out  2  digits accepted in the current field (0..2)
- state  out  2  S_A=00, S_B=01, S_OP=10, S_ISSUE=11
- err  out  1  sticky entry error

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=S_A
  - All outputs 0: alu_in1, alu_in2, alu_selector, issue_valid, entry_value, digit_count, err.
- Priority per cycle: clear > enter > digit_valid.
  - If enter and digit_valid are asserted together, enter acts on the pre-digit accumulator. The digit is dropped silently and err is not set.
- clear (any state):
  - Sets state=S_A, entry_value=0, digit_count=0, err=0, issue_valid=0.
  - alu_in1, alu_in2 and alu_selector keep their last values.
- S_A and S_B, digit handling:
  - If digit_valid, digit_in<=9 and digit_count<2: entry_value <= entry_value*10 + digit_in; digit_count++; err <= 0.
  - If digit_in>9 or digit_count==2: the digit is ignored and err <= 1.
- S_A and S_B, enter handling:
  - Error case: if digit_count==0 or entry_value > 2^OPW-1, set err <= 1 and stay in the current state. The accumulator is kept so the user can clear.
  - Success case, state-specific action: in S_A, alu_in1 <= entry_value[OPW-1:0]; in S_B, alu_in2 <= entry_value[OPW-1:0].
  - Success case, common action: entry_value <= 0, digit_count <= 0, err <= 0. Then S_A -> S_B, or S_B -> S_OP.
- S_OP:
  - Digits are ignored; err is unchanged.
  - On enter: alu_selector <= op_in, issue_valid <= 1 in the next cycle, state -> S_ISSUE.
- S_ISSUE:
  - issue_valid holds high. digit_valid and enter are ignored.
  - The handshake completes in any cycle where issue_valid && issue_ready.
  - On that edge: issue_valid <= 0, state -> S_A. alu_in1, alu_in2 and alu_selector stay stable until the next commit.
  - issue_ready is don't-care outside S_ISSUE.
- Latency:
  - Enter to register update: 1 clock.
  - Enter in S_OP to issue_valid high: 1 clock.
  - Back-to-back issues are not possible; at least one new entry cycle is needed.
- Arithmetic:
  - The accumulator is 7 bits. The maximum is 99, so *10 never overflows.
  - The range check uses the full 7-bit value before truncation.
- Reset mid-operation (rst_n asserted in any state, including S_ISSUE with issue_valid high): all outputs clear asynchronously; no handshake completes.

Test Plan:
- Digits 1,0, enter; digits 5, enter; op_in=2'b01, enter; issue_ready=1 -> alu_in1=10, alu_in2=5, alu_selector=01, issue_valid high exactly one cycle, state returns to 00.
- Digits 1,6, enter in S_A -> err=1, state=00, entry_value=16, alu_in1 unchanged; then clear, digits 9, enter -> alu_in1=9, err=0, state=01.
- Third digit (1,2,3) -> entry_value=12, digit_count=2, err=1; digit_in=4'hB -> ignored, err=1; enter with no digits -> err=1.
- In S_ISSUE with issue_ready=0 for 5 cycles -> issue_valid stays high, outputs stable, digits and enter ignored; issue_ready=1 -> issue_valid drops next edge, state=00.
- enter and digit_valid (digit 7) same cycle after digit 3 in S_A -> alu_in1=3, digit 7 dropped, err=0; clear and enter same cycle in S_OP -> state=00, no issue.
- rst_n low mid-S_ISSUE (asynchronous, between edges) -> all outputs 0 immediately, state=00; after release, a full A=15, B=0, op=11 sequence issues correctly.
